operand_switch: RTL and testbench

//  Registered 2:1 operand/opcode selector in front of the ALU. Chooses between the

---
 rtl/operand_switch_if.sv | 50 +++++
 rtl/operand_switch.sv | 102 ++++++++++
 tb/tb_operand_switch.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/operand_switch_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : operand_switch_if                                            |
// | Description : Bundle of operand/opcode source buses and selected outputs   |
// |               for operand_switch.                                          |
// |   mode                     source select (0 manual, 1 CPU)                 |
// |   manual_a/b/opcode/valid  manual (board switch) source                    |
// |   cpu_a/b/opcode/valid     CPU source                                      |
// |   select_a/b/opcode        registered selected operand pair and opcode     |
// |   select_valid             selected outputs updated this cycle             |
// |   select_src               source of current outputs (0 manual, 1 CPU)     |
// |   mode_changed             one-cycle pulse on effective mode toggle        |
// |   Modports: master drives the sources, slave is the selector.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface operand_switch_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3
);
  logic              mode;
  logic [DATA_W-1:0] manual_a;
  logic [DATA_W-1:0] manual_b;
  logic [OP_W-1:0]   manual_opcode;
  logic              manual_valid;
  logic [DATA_W-1:0] cpu_a;
  logic [DATA_W-1:0] cpu_b;
  logic [OP_W-1:0]   cpu_opcode;
  logic              cpu_valid;
  logic [DATA_W-1:0] select_a;
  logic [DATA_W-1:0] select_b;
  logic [OP_W-1:0]   select_opcode;
  logic              select_valid;
  logic              select_src;
  logic              mode_changed;

  modport master (
    output mode,
    output manual_a, manual_b, manual_opcode, manual_valid,
    output cpu_a, cpu_b, cpu_opcode, cpu_valid,
    input  select_a, select_b, select_opcode, select_valid, select_src, mode_changed
  );

  modport slave (
    input  mode,
    input  manual_a, manual_b, manual_opcode, manual_valid,
    input  cpu_a, cpu_b, cpu_opcode, cpu_valid,
    output select_a, select_b, select_opcode, select_valid, select_src, mode_changed
  );
endinterface
`default_nettype wire

// File: rtl/operand_switch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : operand_switch                                               |
// | Description : Registered 2:1 operand/opcode selector in front of the ALU.  |
// |               Picks the manual or CPU source according to mode, presents   |
// |               one operand pair plus opcode per cycle with a valid flag,    |
// |               the source tag and a one-cycle mode-change pulse.            |
// |   clk    : system clock, rising edge                                       |
// |   rst_n  : asynchronous active-low reset                                   |
// |   sw     : operand_switch_if.slave (sources in, selected outputs out)      |
// |   Option : SWITCH_MODE_SYNC_EN - when defined, mode goes through a 2-flop  |
// |            synchronizer before use (mode-to-output latency 3 clk instead   |
// |            of 1 clk; mode_changed delayed equally).                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module operand_switch #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  operand_switch_if.slave   sw
);

  logic              w_mode_eff;
  logic              w_sel_valid;
  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;
  logic [OP_W-1:0]   w_sel_opcode;

  logic              r_mode_q;
  logic [DATA_W-1:0] r_select_a;
  logic [DATA_W-1:0] r_select_b;
  logic [OP_W-1:0]   r_select_opcode;
  logic              r_select_valid;
  logic              r_select_src;
  logic              r_mode_changed;

`ifdef SWITCH_MODE_SYNC_EN
  // mode comes from an asynchronous board switch: two flops before any use.
  logic [1:0] r_mode_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_sync <= 2'b00;
    end else begin
      r_mode_sync <= {r_mode_sync[0], sw.mode};
    end
  end

  assign w_mode_eff = r_mode_sync[1];
`else
  // mode is assumed synchronous to clk and used directly.
  assign w_mode_eff = sw.mode;
`endif

  // The unselected source, including its valid, never reaches the registers.
  always_comb begin
    w_sel_valid  = sw.manual_valid;
    w_sel_a      = sw.manual_a;
    w_sel_b      = sw.manual_b;
    w_sel_opcode = sw.manual_opcode;
    if (w_mode_eff) begin
      w_sel_valid  = sw.cpu_valid;
      w_sel_a      = sw.cpu_a;
      w_sel_b      = sw.cpu_b;
      w_sel_opcode = sw.cpu_opcode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q        <= 1'b0;
      r_select_a      <= '0;
      r_select_b      <= '0;
      r_select_opcode <= '0;
      r_select_valid  <= 1'b0;
      r_select_src    <= 1'b0;
      r_mode_changed  <= 1'b0;
    end else begin
      r_mode_q       <= w_mode_eff;
      // The toggle cycle already selects the new source: no bubble inserted.
      r_mode_changed <= (w_mode_eff != r_mode_q);
      r_select_valid <= w_sel_valid;
      if (w_sel_valid) begin
        r_select_a      <= w_sel_a;
        r_select_b      <= w_sel_b;
        r_select_opcode <= w_sel_opcode;
        r_select_src    <= w_mode_eff;
      end
    end
  end

  assign sw.select_a      = r_select_a;
  assign sw.select_b      = r_select_b;
  assign sw.select_opcode = r_select_opcode;
  assign sw.select_valid  = r_select_valid;
  assign sw.select_src    = r_select_src;
  assign sw.mode_changed  = r_mode_changed;

endmodule
`default_nettype wire

// File: tb/tb_operand_switch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_operand_switch                                            |
// | Description : Self-checking bench for operand_switch: directed scenarios   |
// |               followed by random traffic, all compared against a           |
// |               behavioural model of the selector.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_operand_switch;
  localparam int DW = 8;
  localparam int OW = 3;

  logic clk = 1'b0;
  logic rst_n;

  operand_switch_if #(.DATA_W(DW), .OP_W(OW)) sw ();

  operand_switch #(.DATA_W(DW), .OP_W(OW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: what the selected outputs should be after each rising edge.
  logic [DW-1:0] m_a, m_b;
  logic [OW-1:0] m_op;
  logic          m_valid, m_src, m_chg;
  logic          m_last_mode;   // effective mode seen at the previous edge
  bit            m_hist[$];     // modes sampled at earlier edges (sync option)

  task automatic model_reset();
    m_a = '0; m_b = '0; m_op = '0;
    m_valid = 1'b0; m_src = 1'b0; m_chg = 1'b0; m_last_mode = 1'b0;
    m_hist.delete();
    m_hist.push_back(1'b0);
    m_hist.push_back(1'b0);
  endtask

  // Applies one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    logic eff;
`ifdef SWITCH_MODE_SYNC_EN
    eff = m_hist.pop_front();
    m_hist.push_back(sw.mode);
`else
    eff = sw.mode;
`endif
    m_chg       = (eff !== m_last_mode);
    m_last_mode = eff;
    if (eff == 1'b1 && sw.cpu_valid == 1'b1) begin
      {m_a, m_b, m_op} = {sw.cpu_a, sw.cpu_b, sw.cpu_opcode};
      m_src = 1'b1; m_valid = 1'b1;
    end else if (eff == 1'b0 && sw.manual_valid == 1'b1) begin
      {m_a, m_b, m_op} = {sw.manual_a, sw.manual_b, sw.manual_opcode};
      m_src = 1'b0; m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".a"},     32'(sw.select_a),      32'(m_a));
    check({tag, ".b"},     32'(sw.select_b),      32'(m_b));
    check({tag, ".op"},    32'(sw.select_opcode), 32'(m_op));
    check({tag, ".valid"}, 32'(sw.select_valid),  32'(m_valid));
    check({tag, ".src"},   32'(sw.select_src),    32'(m_src));
    check({tag, ".chg"},   32'(sw.mode_changed),  32'(m_chg));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    model_edge();
    check_all(tag);
  endtask

  task automatic set_man(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic v);
    sw.manual_a = a; sw.manual_b = b; sw.manual_opcode = op; sw.manual_valid = v;
  endtask

  task automatic set_cpu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic v);
    sw.cpu_a = a; sw.cpu_b = b; sw.cpu_opcode = op; sw.cpu_valid = v;
  endtask

  initial begin
    // Reset with every input pulled high: outputs must stay zero.
    rst_n   = 1'b0;
    sw.mode = 1'b1;
    set_man(8'd255, 8'd255, 3'd7, 1'b1);
    set_cpu(8'd255, 8'd255, 3'd7, 1'b1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    #2 rst_n = 1'b1;

    // Manual source selected; CPU source ignored.
    sw.mode = 1'b0;
    set_man(8'd10, 8'd5, 3'b000, 1'b1);
    set_cpu(8'd100, 8'd50, 3'b001, 1'b1);
    step("manual1");
`ifdef SWITCH_MODE_SYNC_EN
    repeat (2) step("manual1_settle");
`endif
    set_man(8'd20, 8'd3, 3'b010, 1'b1);
    step("manual2");

    // Switch to CPU; manual carries 3'b111 and must be ignored.
    sw.mode = 1'b1;
    set_man(8'd99, 8'd88, 3'b111, 1'b1);
    set_cpu(8'd40, 8'd8, 3'b011, 1'b1);
    step("cpu1");
`ifdef SWITCH_MODE_SYNC_EN
    repeat (2) step("cpu1_settle");
`endif
    set_cpu(8'd25, 8'd25, 3'b101, 1'b1);
    step("cpu2");

    // Hold: selected source not valid.
    set_cpu(8'd60, 8'd30, 3'b110, 1'b0);
    step("hold");

    // Back-to-back toggles 0 -> 1 -> 0.
    set_man(8'd50, 8'd25, 3'b000, 1'b1);
    set_cpu(8'd80, 8'd20, 3'b010, 1'b1);
    sw.mode = 1'b0; step("sw0");
    sw.mode = 1'b1; step("sw1");
    sw.mode = 1'b0; step("sw2");
    repeat (3) step("sw_tail");

    // Edge values in both modes.
    for (int m = 0; m < 2; m++) begin
      sw.mode = m[0];
      set_man(8'h00, 8'h00, 3'b000, 1'b1);
      set_cpu(8'h00, 8'h00, 3'b000, 1'b1);
      repeat (3) step("zeros");
      set_man(8'hFF, 8'hFF, 3'b111, 1'b1);
      set_cpu(8'hFF, 8'hFF, 3'b111, 1'b1);
      step("ones");
    end

    // Asynchronous reset mid-operation: cleared with no clock edge.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #2 rst_n = 1'b1;
    step("post_rst");

    // Random traffic, mode biased to stay put but toggling often.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) sw.mode = ~sw.mode;
      set_man(8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom_range(0, 3) != 0));
      set_cpu(8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 15) == 0) begin
        set_man(8'hFF, 8'h00, 3'b111, 1'b1);
        set_cpu(8'h00, 8'hFF, 3'b000, 1'b1);
      end
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
